// File: rtl/hazard_controller.sv
// hazard_controller: pipeline stall/bubble/flush controller for the five-stage core.
// Covers load-use hazards, taken branches, and instruction/data memory wait states.
// A watchdog counts data-memory wait cycles and sets a sticky flag once the
// count reaches MEM_TIMEOUT.
// Optional feature macro: HAZARD_PERF_CNT_EN adds the stall-cycle and
// branch-flush performance counters. When it is undefined, both outputs are 0.
//
// Writeback source encoding on id_ex_data_dest_i is 00=ALU, 01=MEM, 10=PC.
module hazard_controller #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  reg_addr1_i,
    input  logic [4:0]  reg_addr2_i,
    input  logic        rs1_used_i,
    input  logic        rs2_used_i,
    input  logic [4:0]  id_ex_reg_wr_addr_i,
    input  logic        id_ex_reg_wr_sig_i,
    input  logic [1:0]  id_ex_data_dest_i,
    input  logic        branch_taken_i,
    input  logic        imem_ready_i,
    input  logic        dmem_req_i,
    input  logic        dmem_ready_i,
    output logic        pc_stall_o,
    output logic        if_id_stall_o,
    output logic        if_id_flush_o,
    output logic        id_ex_stall_o,
    output logic        id_ex_bubble_o,
    output logic        ex_mem_stall_o,
    output logic        mem_wb_bubble_o,
    output logic        mem_wait_o,
    output logic        mem_timeout_o,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_count_o
);

    localparam logic [1:0] DEST_MEM    = 2'b01;
    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_wait_q, mem_wait_d;
    logic       mem_timeout_q, mem_timeout_d;

    logic       load_use;
    logic       mem_stall;
    logic       branch_flush;

    // A load in ID/EX whose rd (not x0) is read by the decode instruction.
    assign load_use = id_ex_reg_wr_sig_i
                   && (id_ex_data_dest_i == DEST_MEM)
                   && (id_ex_reg_wr_addr_i != 5'd0)
                   && (((id_ex_reg_wr_addr_i == reg_addr1_i) && rs1_used_i)
                    || ((id_ex_reg_wr_addr_i == reg_addr2_i) && rs2_used_i));

    // The data memory has not finished the access that EX/MEM is waiting on.
    assign mem_stall = dmem_req_i && !dmem_ready_i;

    // Prioritised pipeline controls. Only the highest active cause drives outputs.
    always_comb begin
        pc_stall_o      = 1'b0;
        if_id_stall_o   = 1'b0;
        if_id_flush_o   = 1'b0;
        id_ex_stall_o   = 1'b0;
        id_ex_bubble_o  = 1'b0;
        ex_mem_stall_o  = 1'b0;
        mem_wb_bubble_o = 1'b0;
        branch_flush    = 1'b0;
        if (!rst_i) begin
            if (mem_stall) begin
                // EX is frozen, so a branch resolved there must wait.
                pc_stall_o      = 1'b1;
                if_id_stall_o   = 1'b1;
                id_ex_stall_o   = 1'b1;
                ex_mem_stall_o  = 1'b1;
                mem_wb_bubble_o = 1'b1;
            end else if (branch_taken_i) begin
                // The PC runs free so that it loads the branch target.
                if_id_flush_o  = 1'b1;
                id_ex_bubble_o = 1'b1;
                branch_flush   = 1'b1;
            end else if (load_use) begin
                // One bubble is enough: the NOP then occupies ID/EX.
                pc_stall_o     = 1'b1;
                if_id_stall_o  = 1'b1;
                id_ex_bubble_o = 1'b1;
            end else if (!imem_ready_i) begin
                pc_stall_o    = 1'b1;
                if_id_flush_o = 1'b1;
            end
        end
    end

    // Next state for the wait FSM, the watchdog counter and the registered flags.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = 8'd0;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (!mem_stall) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q >= TIMEOUT_CNT) begin
                    wait_cnt_d = TIMEOUT_CNT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 8'd0;
            end
        endcase
        mem_wait_d    = (state_d == MEM_WAIT);
        mem_timeout_d = mem_timeout_q || (wait_cnt_d == TIMEOUT_CNT);
    end

    // FSM state, watchdog and registered status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= RUN;
            wait_cnt_q    <= 8'd0;
            mem_wait_q    <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_wait_q    <= mem_wait_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign mem_wait_o    = mem_wait_q;
    assign mem_timeout_o = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Counter increments; both wrap naturally at 2^32.
    always_comb begin
        stall_cycles_d = stall_cycles_q + {31'd0, pc_stall_o};
        flush_count_d  = flush_count_q + {31'd0, branch_flush};
    end

    // Performance counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_count_o  = flush_count_q;
`else
    logic unused_branch_flush;
    assign unused_branch_flush = branch_flush;
    assign stall_cycles_o      = 32'd0;
    assign flush_count_o       = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed testbench for hazard_controller (built with MEM_TIMEOUT=4).
// Control vector order: {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
// id_ex_bubble, ex_mem_stall, mem_wb_bubble}.
module tb_hazard_controller;

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1100100;
    localparam logic [6:0] C_BR   = 7'b0010100;
    localparam logic [6:0] C_MEM  = 7'b1101011;
    localparam logic [6:0] C_IM   = 7'b1010000;

    logic        clk;
    logic        rst;
    logic [4:0]  reg_addr1, reg_addr2, id_ex_rd;
    logic        rs1_used, rs2_used, id_ex_we;
    logic [1:0]  id_ex_dest;
    logic        branch_taken, imem_ready, dmem_req, dmem_ready;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall;
    logic        id_ex_bubble, ex_mem_stall, mem_wb_bubble;
    logic        mem_wait, mem_timeout;
    logic [31:0] stall_cycles, flush_count;

    int errors = 0;
    int checks = 0;
    logic [6:0] ctrl_v;

    hazard_controller #(.MEM_TIMEOUT(4)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .reg_addr1_i         (reg_addr1),
        .reg_addr2_i         (reg_addr2),
        .rs1_used_i          (rs1_used),
        .rs2_used_i          (rs2_used),
        .id_ex_reg_wr_addr_i (id_ex_rd),
        .id_ex_reg_wr_sig_i  (id_ex_we),
        .id_ex_data_dest_i   (id_ex_dest),
        .branch_taken_i      (branch_taken),
        .imem_ready_i        (imem_ready),
        .dmem_req_i          (dmem_req),
        .dmem_ready_i        (dmem_ready),
        .pc_stall_o          (pc_stall),
        .if_id_stall_o       (if_id_stall),
        .if_id_flush_o       (if_id_flush),
        .id_ex_stall_o       (id_ex_stall),
        .id_ex_bubble_o      (id_ex_bubble),
        .ex_mem_stall_o      (ex_mem_stall),
        .mem_wb_bubble_o     (mem_wb_bubble),
        .mem_wait_o          (mem_wait),
        .mem_timeout_o       (mem_timeout),
        .stall_cycles_o      (stall_cycles),
        .flush_count_o       (flush_count)
    );

    // Clock and cycle helpers
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
        ctrl_v = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                  id_ex_bubble, ex_mem_stall, mem_wb_bubble};
    endtask

    // Driver tasks
    task automatic drive_idle();
        reg_addr1 = 5'd1; reg_addr2 = 5'd2; rs1_used = 1'b0; rs2_used = 1'b0;
        id_ex_rd = 5'd0; id_ex_we = 1'b0; id_ex_dest = 2'b00;
        branch_taken = 1'b0; imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [1:0] dest);
        id_ex_rd = rd; id_ex_we = 1'b1; id_ex_dest = dest;
    endtask

    // Scenarios
    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        branch_taken = 1'b1; imem_ready = 1'b0; dmem_req = 1'b1;
        tick();
        settle();
        checks++;
        if (ctrl_v !== C_NONE) begin errors++; $display("FAIL reset_ctrl: got %b expected %b", ctrl_v, C_NONE); end
        drive_idle();
        tick();
        rst = 1'b0;
        settle();
        checks++;
        if ({mem_wait, mem_timeout} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {mem_wait, mem_timeout}); end
        checks++;
        if ({stall_cycles, flush_count} !== 64'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cycles, flush_count); end
        tick();
    endtask

    task automatic test_load_use();
        drive_idle();
        drive_load(5'd5, 2'b01); reg_addr1 = 5'd5; rs1_used = 1'b1;
        settle();
        checks++;
        if (ctrl_v !== C_LU) begin errors++; $display("FAIL load_use_rs1: got %b expected %b", ctrl_v, C_LU); end
        tick();
        // ID/EX now holds the bubble.
        id_ex_we = 1'b0;
        settle();
        checks++;
        if (ctrl_v !== C_NONE) begin errors++; $display("FAIL load_use_clear: got %b expected %b", ctrl_v, C_NONE); end
        drive_idle();
        drive_load(5'd9, 2'b01); reg_addr2 = 5'd9; rs2_used = 1'b1;
        settle();
        checks++;
        if (ctrl_v !== C_LU) begin errors++; $display("FAIL load_use_rs2: got %b expected %b", ctrl_v, C_LU); end
        rs2_used = 1'b0;
        settle();
        checks++;
        if (ctrl_v !== C_NONE) begin errors++; $display("FAIL load_use_unused: got %b expected %b", ctrl_v, C_NONE); end
        drive_idle();
        drive_load(5'd0, 2'b01); reg_addr1 = 5'd0; rs1_used = 1'b1;
        settle();
        checks++;
        if (ctrl_v !== C_NONE) begin errors++; $display("FAIL load_use_x0: got %b expected %b", ctrl_v, C_NONE); end
        drive_load(5'd5, 2'b00); reg_addr1 = 5'd5;
        settle();
        checks++;
        if (ctrl_v !== C_NONE) begin errors++; $display("FAIL load_use_alu: got %b expected %b", ctrl_v, C_NONE); end
        drive_idle();
        tick();
    endtask

    task automatic test_branch();
        drive_idle();
        drive_load(5'd5, 2'b01); reg_addr1 = 5'd5; rs1_used = 1'b1;
        branch_taken = 1'b1;
        settle();
        checks++;
        if (ctrl_v !== C_BR) begin errors++; $display("FAIL branch_over_load_use: got %b expected %b", ctrl_v, C_BR); end
        drive_idle();
        branch_taken = 1'b1; imem_ready = 1'b0;
        settle();
        checks++;
        if (ctrl_v !== C_BR) begin errors++; $display("FAIL branch_over_imem: got %b expected %b", ctrl_v, C_BR); end
        drive_idle();
        tick();
    endtask

    task automatic test_imem_wait();
        drive_idle();
        imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++;
            if (ctrl_v !== C_IM) begin errors++; $display("FAIL imem_wait_%0d: got %b expected %b", i, ctrl_v, C_IM); end
            tick();
        end
        drive_idle();
    endtask

    task automatic test_mem_stall();
        drive_idle();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        branch_taken = 1'b1;
        settle();
        checks++;
        if (ctrl_v !== C_MEM) begin errors++; $display("FAIL mem_stall_c1: got %b expected %b", ctrl_v, C_MEM); end
        checks++;
        if (mem_wait !== 1'b0) begin errors++; $display("FAIL mem_wait_c1: got %b expected 0", mem_wait); end
        for (int c = 2; c <= 3; c++) begin
            tick();
            settle();
            checks++;
            if ({ctrl_v, mem_wait} !== {C_MEM, 1'b1}) begin errors++; $display("FAIL mem_stall_c%0d: got %b/%b expected %b/1", c, ctrl_v, mem_wait, C_MEM); end
        end
        tick();
        branch_taken = 1'b0; dmem_ready = 1'b1;
        settle();
        checks++;
        if ({ctrl_v, mem_wait} !== {C_NONE, 1'b1}) begin errors++; $display("FAIL mem_stall_c4: got %b/%b expected %b/1", ctrl_v, mem_wait, C_NONE); end
        tick();
        drive_idle();
        settle();
        checks++;
        if ({mem_wait, mem_timeout} !== 2'b00) begin errors++; $display("FAIL mem_stall_end: got %b expected 00", {mem_wait, mem_timeout}); end
        // Ready in the first cycle: no stall and no wait state.
        dmem_req = 1'b1; dmem_ready = 1'b1;
        settle();
        checks++;
        if (ctrl_v !== C_NONE) begin errors++; $display("FAIL mem_ready_first: got %b expected %b", ctrl_v, C_NONE); end
        tick();
        settle();
        checks++;
        if (mem_wait !== 1'b0) begin errors++; $display("FAIL mem_ready_first_wait: got %b expected 0", mem_wait); end
        drive_idle();
        tick();
    endtask

    task automatic test_timeout();
        drive_idle();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (mem_timeout !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b expected 0", mem_timeout); end
        tick();
        checks++;
        if (mem_timeout !== 1'b1) begin errors++; $display("FAIL timeout_set: got %b expected 1", mem_timeout); end
        tick(); tick();
        settle();
        checks++;
        if (ctrl_v !== C_MEM) begin errors++; $display("FAIL timeout_still_stalls: got %b expected %b", ctrl_v, C_MEM); end
        dmem_ready = 1'b1;
        tick();
        drive_idle();
        tick();
        checks++;
        if ({mem_timeout, mem_wait} !== 2'b10) begin errors++; $display("FAIL timeout_sticky: got %b expected 10", {mem_timeout, mem_wait}); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (mem_timeout !== 1'b0) begin errors++; $display("FAIL timeout_cleared: got %b expected 0", mem_timeout); end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        drive_idle();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        tick(); tick();
        checks++;
        if (mem_wait !== 1'b1) begin errors++; $display("FAIL mid_wait_entered: got %b expected 1", mem_wait); end
        rst = 1'b1;
        settle();
        checks++;
        if (ctrl_v !== C_NONE) begin errors++; $display("FAIL mid_wait_rst_ctrl: got %b expected %b", ctrl_v, C_NONE); end
        tick();
        rst = 1'b0;
        checks++;
        if (mem_wait !== 1'b0) begin errors++; $display("FAIL mid_wait_run: got %b expected 0", mem_wait); end
        // A fresh count of three must stay below the threshold of four.
        tick(); tick(); tick();
        checks++;
        if (mem_timeout !== 1'b0) begin errors++; $display("FAIL mid_wait_cnt_cleared: got %b expected 0", mem_timeout); end
        drive_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_perf();
        logic [31:0] exp_stall2, exp_flush1, exp_flush2;
`ifdef HAZARD_PERF_CNT_EN
        exp_stall2 = 32'd2; exp_flush1 = 32'd1; exp_flush2 = 32'd2;
`else
        exp_stall2 = 32'd0; exp_flush1 = 32'd0; exp_flush2 = 32'd0;
`endif
        drive_idle();
        imem_ready = 1'b0;
        tick(); tick();
        imem_ready = 1'b1;
        checks++;
        if (stall_cycles !== exp_stall2) begin errors++; $display("FAIL perf_stall: got %0d expected %0d", stall_cycles, exp_stall2); end
        branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0;
        checks++;
        if (flush_count !== exp_flush1) begin errors++; $display("FAIL perf_flush1: got %0d expected %0d", flush_count, exp_flush1); end
        drive_load(5'd5, 2'b01); reg_addr1 = 5'd5; rs1_used = 1'b1; branch_taken = 1'b1;
        tick();
        drive_idle();
        checks++;
        if ({flush_count, stall_cycles} !== {exp_flush2, exp_stall2}) begin errors++; $display("FAIL perf_flush2: got %0d/%0d expected %0d/%0d", flush_count, stall_cycles, exp_flush2, exp_stall2); end
    endtask

    // Test sequence and final report
    initial begin
        drive_idle();
        rst = 1'b1;
        tick();
        test_reset();
        test_load_use();
        test_branch();
        test_imem_wait();
        test_mem_stall();
        test_timeout();
        test_reset_mid_wait();
        test_perf();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
